// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants and shared types for the VGA timing path.
package vga_timing_pkg;

   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;

   localparam int VGA_H_TOTAL     = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
   localparam int VGA_V_TOTAL     = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;
   localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_H_ACT_END   = VGA_H_ACT_START + VGA_H_ACTIVE - 1;
   localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BACK;
   localparam int VGA_V_ACT_END   = VGA_V_ACT_START + VGA_V_ACTIVE - 1;

   localparam int COORD_W = 10;
   localparam int COLOR_W = 24;

   // Sideband travelling alongside the pixel request; raw syncs are active-high.
   typedef struct packed {
      logic vld;
      logic hs;
      logic vs;
   } sync_t;

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register; DEPTH=0 is a plain wire.
module vga_delay_line #(
   parameter int                 WIDTH       = 1,
   parameter int                 DEPTH       = 1,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic             vga_clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q = d;
      end else begin : g_pipe
         logic [DEPTH-1:0][WIDTH-1:0] pipe;

         always_ff @(posedge vga_clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe <= {DEPTH{RESET_VALUE}};
            end else begin
               pipe[0] <= d;
               for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign q = pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster counters, registered pixel request to the sources, and latency-aligned
// sync/de/rgb output stage towards the DAC.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int H_SYNC        = VGA_H_SYNC,
   parameter int H_BACK        = VGA_H_BACK,
   parameter int H_ACTIVE      = VGA_H_ACTIVE,
   parameter int H_FRONT       = VGA_H_FRONT,
   parameter int V_SYNC        = VGA_V_SYNC,
   parameter int V_BACK        = VGA_V_BACK,
   parameter int V_ACTIVE      = VGA_V_ACTIVE,
   parameter int V_FRONT       = VGA_V_FRONT,
   parameter int PIXEL_LATENCY = 1
) (
   input  logic               vga_clk,
   input  logic               rst_n,
   input  logic [COLOR_W-1:0] pos_data,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic               pos_valid,
   output logic               frame_start,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COLOR_W-1:0] rgb
);

   localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
   localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
   localparam logic [COORD_W-1:0] HA_LO   = COORD_W'(H_SYNC + H_BACK);
   localparam logic [COORD_W-1:0] HA_HI   = COORD_W'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [COORD_W-1:0] VA_LO   = COORD_W'(V_SYNC + V_BACK);
   localparam logic [COORD_W-1:0] VA_HI   = COORD_W'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_SYNC);
   localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_SYNC);
   // Rows are reported one-based, so the subtrahend sits one below the first active line.
   localparam logic [COORD_W-1:0] VY_OFF  = COORD_W'(V_SYNC + V_BACK - 1);

   logic [COORD_W-1:0] h_cnt, v_cnt;
   logic               act;
   logic               hs_s1, vs_s1;
   sync_t              s1, sd;

   assign act = (h_cnt >= HA_LO) && (h_cnt < HA_HI) && (v_cnt >= VA_LO) && (v_cnt < VA_HI);

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_valid   <= 1'b0;
         pos_x       <= '0;
         pos_y       <= '0;
         frame_start <= 1'b0;
         hs_s1       <= 1'b0;
         vs_s1       <= 1'b0;
      end else begin
         pos_valid   <= act;
         pos_x       <= act ? h_cnt - HA_LO  : '0;
         pos_y       <= act ? v_cnt - VY_OFF : '0;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         hs_s1       <= h_cnt < HS_END;
         vs_s1       <= v_cnt < VS_END;
      end
   end

   assign s1 = '{vld: pos_valid, hs: hs_s1, vs: vs_s1};

   vga_delay_line #(
      .WIDTH       ($bits(sync_t)),
      .DEPTH       (PIXEL_LATENCY),
      .RESET_VALUE ('0)
   ) u_align (
      .vga_clk (vga_clk),
      .rst_n   (rst_n),
      .d       (s1),
      .q       (sd)
   );

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         de    <= 1'b0;
         rgb   <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         de    <= sd.vld;
         rgb   <= sd.vld ? pos_data : '0;
         hsync <= ~sd.hs;
         vsync <= ~sd.vs;
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: full-size 640x480 instance (L=1) over the first 38 lines, plus a
// miniature-geometry instance (L=3) that wraps many frames and takes a mid-frame reset.
module tb_vga_timing_ctrl;

   typedef struct packed {
      int hs; int hb; int ha; int hf;
      int vs; int vb; int va; int vf;
      int lat;
   } geo_t;

   typedef struct packed {
      logic        pv;
      logic [9:0]  px;
      logic [9:0]  py;
      logic        fs;
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
   } exp_t;

   localparam geo_t GM = '{96, 48, 640, 16, 2, 33, 480, 10, 1};
   localparam geo_t GS = '{3, 2, 4, 1, 1, 2, 3, 1, 3};
   localparam int   RUN = 30000;

   logic        vga_clk = 1'b0;
   logic        rst_n, rst_s_n;
   logic [23:0] pd_m, pd_s;
   logic [23:0] s_q1, s_q2, s_q3;

   logic [9:0]  px_m, py_m, px_s, py_s;
   logic        pv_m, fs_m, hs_m, vs_m, de_m;
   logic        pv_s, fs_s, hs_s, vs_s, de_s;
   logic [23:0] rgb_m, rgb_s;

   int nvec = 0;
   int nmis = 0;

   always #20 vga_clk = ~vga_clk;

   vga_timing_ctrl #(.PIXEL_LATENCY(1)) u_dut (
      .vga_clk(vga_clk), .rst_n(rst_n), .pos_data(pd_m),
      .pos_x(px_m), .pos_y(py_m), .pos_valid(pv_m), .frame_start(fs_m),
      .hsync(hs_m), .vsync(vs_m), .de(de_m), .rgb(rgb_m)
   );

   vga_timing_ctrl #(
      .H_SYNC(3), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(1),
      .V_SYNC(1), .V_BACK(2), .V_ACTIVE(3), .V_FRONT(1),
      .PIXEL_LATENCY(3)
   ) u_sml (
      .vga_clk(vga_clk), .rst_n(rst_s_n), .pos_data(pd_s),
      .pos_x(px_s), .pos_y(py_s), .pos_valid(pv_s), .frame_start(fs_s),
      .hsync(hs_s), .vsync(vs_s), .de(de_s), .rgb(rgb_s)
   );

   // Pixel sources: colour derived from the coordinates, returned L cycles later.
   always @(posedge vga_clk) begin
      pd_m <= {px_m[7:0], py_m[7:0], 8'hA5};
      s_q1 <= {px_s[7:0], py_s[7:0], 8'h3C};
      s_q2 <= s_q1;
      s_q3 <= s_q2;
   end
   assign pd_s = s_q3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs after n clock edges since reset release (n=0: in/at reset).
   function automatic exp_t model(geo_t g, int n, logic [7:0] tag);
      exp_t e;
      int ht, vt, hlo, vlo, c, h, v;
      bit a;
      ht  = g.hs + g.hb + g.ha + g.hf;
      vt  = g.vs + g.vb + g.va + g.vf;
      hlo = g.hs + g.hb;
      vlo = g.vs + g.vb;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      c = n - 1;
      if (c >= 0) begin
         h = c % ht;
         v = (c / ht) % vt;
         a = (h >= hlo) && (h < hlo + g.ha) && (v >= vlo) && (v < vlo + g.va);
         e.pv = a;
         e.fs = (h == 0) && (v == 0);
         if (a) begin
            e.px = 10'(h - hlo);
            e.py = 10'(v - vlo + 1);
         end
      end
      c = n - 2 - g.lat;
      if (c >= 0) begin
         h = c % ht;
         v = (c / ht) % vt;
         a = (h >= hlo) && (h < hlo + g.ha) && (v >= vlo) && (v < vlo + g.va);
         e.de = a;
         e.hs = !(h < g.hs);
         e.vs = !(v < g.vs);
         if (a) e.rgb = {8'(h - hlo), 8'(v - vlo + 1), tag};
      end
      return e;
   endfunction

   task automatic check_m(input int n);
      exp_t e;
      e = model(GM, n, 8'hA5);
      chk("m.pos_valid",   32'(pv_m),  32'(e.pv));
      chk("m.pos_x",       32'(px_m),  32'(e.px));
      chk("m.pos_y",       32'(py_m),  32'(e.py));
      chk("m.frame_start", 32'(fs_m),  32'(e.fs));
      chk("m.de",          32'(de_m),  32'(e.de));
      chk("m.hsync",       32'(hs_m),  32'(e.hs));
      chk("m.vsync",       32'(vs_m),  32'(e.vs));
      chk("m.rgb",         32'(rgb_m), 32'(e.rgb));
   endtask

   task automatic check_s(input int n);
      exp_t e;
      e = model(GS, n, 8'h3C);
      chk("s.pos_valid",   32'(pv_s),  32'(e.pv));
      chk("s.pos_x",       32'(px_s),  32'(e.px));
      chk("s.pos_y",       32'(py_s),  32'(e.py));
      chk("s.frame_start", 32'(fs_s),  32'(e.fs));
      chk("s.de",          32'(de_s),  32'(e.de));
      chk("s.hsync",       32'(hs_s),  32'(e.hs));
      chk("s.vsync",       32'(vs_s),  32'(e.vs));
      chk("s.rgb",         32'(rgb_s), 32'(e.rgb));
   endtask

   initial begin
      int n, ns, s_rst_cnt, hs_lo, vs_lo, de_cnt, fs_cnt, s_fs_cnt;
      bit did_rst;
      n = 0; ns = 0; s_rst_cnt = 0; did_rst = 0;
      hs_lo = 0; vs_lo = 0; de_cnt = 0; fs_cnt = 0; s_fs_cnt = 0;
      rst_n   = 1'b0;
      rst_s_n = 1'b0;
      repeat (3) @(negedge vga_clk);
      check_m(0);
      check_s(0);
      rst_n   = 1'b1;
      rst_s_n = 1'b1;

      for (int i = 0; i < RUN; i++) begin
         @(posedge vga_clk);
         n++;
         ns++;
         @(negedge vga_clk);
         check_m(n);
         if (!hs_m) hs_lo++;
         if (!vs_m) vs_lo++;
         if (de_m)  de_cnt++;
         if (fs_m)  fs_cnt++;

         if (s_rst_cnt > 0) begin
            check_s(0);
            s_rst_cnt--;
            if (s_rst_cnt == 0) begin
               rst_s_n = 1'b1;
               ns = 0;
            end
         end else begin
            check_s(ns);
            if (did_rst && fs_s) s_fs_cnt++;
            // Mid-frame reset with the small raster's stage 1 at (h=4, v=2).
            if (!did_rst && n >= 2000 && ((ns - 1) % 70) == 24) begin
               rst_s_n = 1'b0;
               #1;
               check_s(0);
               did_rst   = 1;
               s_rst_cnt = 3;
            end
         end
      end

      // Hand-counted over output pixels c=-2..29997 of the 800x525 raster.
      chk("m.hsync_low_cycles", 32'(hs_lo),  32'd3648);
      chk("m.vsync_low_cycles", 32'(vs_lo),  32'd1600);
      chk("m.de_cycles",        32'(de_cnt), 32'd1534);
      chk("m.frame_starts",     32'(fs_cnt), 32'd1);
      chk("s.reset_taken",      32'(did_rst), 32'd1);
      chk("s.frame_starts_after_reset_nonzero", 32'(s_fs_cnt > 0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
